// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the datapath sequencer: instruction field layout, opcodes, FSM states, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package datapath_controller_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;

    // Instruction word: [15:12] op, [11:8] dst, [7:4] a, [3:0] b; LDI reuses [7:0] as immediate
    localparam int F_OP_HI  = 15;
    localparam int F_OP_LO  = 12;
    localparam int F_DST_HI = 11;
    localparam int F_DST_LO = 8;
    localparam int F_A_HI   = 7;
    localparam int F_A_LO   = 4;
    localparam int F_B_HI   = 3;
    localparam int F_B_LO   = 0;
    localparam int F_IMM_HI = 7;
    localparam int F_IMM_LO = 0;

    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_LDI  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Everything the datapath sees; held in falling-edge flops in the top
    typedef struct packed {
        logic       we;
        logic       mux;
        logic [7:0] imm;
        logic [3:0] dst;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } ctrl_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Bundles host, instruction-memory and datapath-control signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: imem_req is held until imem_ack; start is ignored while busy.
interface datapath_controller_if
    import datapath_controller_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();

    // Host side
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic               busy;
    logic               done;

    // Instruction memory side
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    // Datapath control side
    logic               writeEnable;
    logic               muxSel;
    logic [7:0]         inputData;
    logic [3:0]         dstSel;
    logic [3:0]         A_sel;
    logic [3:0]         B_sel;
    logic [3:0]         OP_Sel;

    // Controller view
    modport master (
        input  start, start_addr, imem_ack, imem_data,
        output busy, done, imem_req, imem_addr,
        output writeEnable, muxSel, inputData, dstSel, A_sel, B_sel, OP_Sel
    );

    // Environment view (host + memory + datapath)
    modport slave (
        output start, start_addr, imem_ack, imem_data,
        input  busy, done, imem_req, imem_addr,
        input  writeEnable, muxSel, inputData, dstSel, A_sel, B_sel, OP_Sel
    );

endinterface

// File: rtl/datapath_controller_instr_decode.sv
// Maps a latched instruction plus the currently held controls to the next control bundle.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module datapath_controller_instr_decode
    import datapath_controller_pkg::*;
(
    input  logic [INSTR_W_DEF-1:0] i_instr,
    input  ctrl_t                  i_cur,
    output ctrl_t                  o_nxt,
    output logic                   o_is_halt
);

    logic [3:0] w_op;

    assign w_op = i_instr[F_OP_HI:F_OP_LO];

    // Fields not touched by an opcode keep their current value so the datapath sees stable selects
    always_comb begin
        o_nxt     = i_cur;
        o_nxt.we  = 1'b0;
        o_is_halt = 1'b0;
        if (w_op == OP_HALT) begin
            o_is_halt = 1'b1;
        end else if (w_op == OP_LDI) begin
            o_nxt.we  = 1'b1;
            o_nxt.mux = 1'b1;
            o_nxt.dst = i_instr[F_DST_HI:F_DST_LO];
            o_nxt.imm = i_instr[F_IMM_HI:F_IMM_LO];
        end else begin
            o_nxt.we  = 1'b1;
            o_nxt.mux = 1'b0;
            o_nxt.dst = i_instr[F_DST_HI:F_DST_LO];
            o_nxt.a   = i_instr[F_A_HI:F_A_LO];
            o_nxt.b   = i_instr[F_B_HI:F_B_LO];
            o_nxt.op  = w_op;
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Fetches 16-bit instructions and sequences one datapath register write per instruction.
// Latency: 2 cycles per instruction minimum (FETCH with same-cycle ack, then EXEC); done 2 cycles after HALT ack.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; start ignored unless idle.
module datapath_controller
    import datapath_controller_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    datapath_controller_if.master bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic               r_busy;
    logic [INSTR_W-1:0] r_instr;
    ctrl_t              r_ctrl;
    ctrl_t              w_ctrl_nxt;
    logic               w_is_halt;
    logic               w_start_ok;
    logic               w_fetch_ok;

    assign w_start_ok = (r_state == ST_IDLE)  && bus.start;
    assign w_fetch_ok = (r_state == ST_FETCH) && bus.imem_ack;

    datapath_controller_instr_decode u_decode (
        .i_instr   (r_instr),
        .i_cur     (r_ctrl),
        .o_nxt     (w_ctrl_nxt),
        .o_is_halt (w_is_halt)
    );

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start)    w_state_nxt = ST_FETCH;
            ST_FETCH: if (bus.imem_ack) w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = w_is_halt ? ST_DONE : ST_FETCH;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Program counter, busy flag and instruction latch (pc wraps naturally at 2**PC_W)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_busy  <= 1'b0;
            r_instr <= '0;
        end else begin
            if (w_start_ok) begin
                r_pc   <= bus.start_addr;
                r_busy <= 1'b1;
            end
            if (w_fetch_ok) begin
                r_instr <= bus.imem_data;
                r_pc    <= r_pc + PC_W'(1);
            end
            if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Falling-edge control flops: the write strobe opens mid-EXEC and closes half a cycle
    // after the datapath's capturing edge, so clk & writeEnable never glitches
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else if (r_state == ST_EXEC) begin
            r_ctrl <= w_ctrl_nxt;
        end else begin
            r_ctrl.we <= 1'b0;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = (r_state == ST_DONE);
    assign bus.imem_req    = (r_state == ST_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.writeEnable = r_ctrl.we;
    assign bus.muxSel      = r_ctrl.mux;
    assign bus.inputData   = r_ctrl.imm;
    assign bus.dstSel      = r_ctrl.dst;
    assign bus.A_sel       = r_ctrl.a;
    assign bus.B_sel       = r_ctrl.b;
    assign bus.OP_Sel      = r_ctrl.op;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: instruction-memory responder, scoreboard queues, decoupled monitor.
// Latency: n/a.
// Backpressure: responder acks after a programmable number of request cycles.
module tb_datapath_controller;

    typedef struct packed {
        logic [3:0] dst;
        logic       mux;
        logic [7:0] imm;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    datapath_controller_if #(.PC_W(8), .INSTR_W(16)) dif ();

    datapath_controller #(.PC_W(8), .INSTR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.master)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;
    int last_fetch_cyc = 0;
    int ack_dly = 0;
    bit stray   = 1'b0;

    logic [15:0] mem [256];
    logic [7:0]  exp_addr_q [$];
    wr_t         exp_wr_q   [$];
    int          exp_done_q [$];

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    function automatic wr_t mk(input logic [3:0] d, input logic m, input logic [7:0] i,
                               input logic [3:0] a, input logic [3:0] b, input logic [3:0] o);
        wr_t w;
        w = {d, m, i, a, b, o};
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: ack after ack_dly request cycles; garbage (HALT) data when not acking
    initial begin
        int wcnt;
        wcnt = 0;
        dif.imem_ack  = 1'b0;
        dif.imem_data = 16'hE000;
        forever begin
            @(posedge clk); #1;
            dif.imem_ack  = 1'b0;
            dif.imem_data = 16'hE000;
            if (rst_n !== 1'b1) begin
                wcnt = 0;
            end else if (dif.imem_req) begin
                if (wcnt >= ack_dly) begin
                    dif.imem_ack  = 1'b1;
                    dif.imem_data = mem[dif.imem_addr];
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (stray && cyc[0]) begin
                    dif.imem_ack  = 1'b1;
                    dif.imem_data = 16'hF0FF;
                end
            end
        end
    end

    // Monitor: samples mid-cycle (clk low, after the falling-edge update) and pops the scoreboard
    initial begin
        bit         req_prev, ack_prev, we_prev;
        logic [7:0] addr_prev;
        logic [7:0] ea;
        wr_t        got, ew;
        req_prev = 0; ack_prev = 0; we_prev = 0; addr_prev = '0;
        forever begin
            @(negedge clk); #1;
            if (dif.imem_req) begin
                if (req_prev && !ack_prev)
                    check(dif.imem_addr == addr_prev, "addr_hold", 32'(dif.imem_addr), 32'(addr_prev));
                check(!dif.writeEnable, "we_during_fetch", 32'(dif.writeEnable), 32'(0));
                if (dif.imem_ack) begin
                    check(exp_addr_q.size() != 0, "fetch_expected", 32'(dif.imem_addr), 32'(0));
                    if (exp_addr_q.size() != 0) begin
                        ea = exp_addr_q.pop_front();
                        check(dif.imem_addr == ea, "fetch_addr", 32'(dif.imem_addr), 32'(ea));
                    end
                    last_fetch_cyc = cyc;
                end
            end
            req_prev  = dif.imem_req;
            ack_prev  = dif.imem_ack;
            addr_prev = dif.imem_addr;

            if (dif.writeEnable) begin
                check(!we_prev, "we_one_edge", 32'(we_prev), 32'(0));
                wr_cnt++;
                got = {dif.dstSel, dif.muxSel, dif.inputData, dif.A_sel, dif.B_sel, dif.OP_Sel};
                check(exp_wr_q.size() != 0, "write_expected", 32'(got), 32'(0));
                if (exp_wr_q.size() != 0) begin
                    ew = exp_wr_q.pop_front();
                    check(got == ew, "write_fields", 32'(got), 32'(ew));
                end
            end
            we_prev = dif.writeEnable;

            if (dif.done) begin
                done_cnt++;
                check(exp_done_q.size() != 0, "done_expected", 32'(1), 32'(0));
                if (exp_done_q.size() != 0) begin
                    void'(exp_done_q.pop_front());
                    check(cyc - last_fetch_cyc == 2, "done_latency", 32'(cyc - last_fetch_cyc), 32'(2));
                end
            end
        end
    end

    // Strobe may only move while clk is low
    always @(dif.writeEnable) begin
        if (rst_n === 1'b1) check(clk == 1'b0, "we_edge_clk_low", 32'(clk), 32'(0));
    end

    task automatic pulse_start(input logic [7:0] a);
        @(posedge clk); #1;
        dif.start      = 1'b1;
        dif.start_addr = a;
        @(posedge clk); #1;
        dif.start      = 1'b0;
        dif.start_addr = 8'h00;
    endtask

    task automatic wait_done(input int maxc);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < maxc) begin
            @(posedge clk);
            i++;
        end
        check(done_cnt != d0, "done_timeout", 32'(done_cnt - d0), 32'(1));
        @(negedge clk); #2;
        check(dif.busy == 1'b0, "busy_after_done", 32'(dif.busy), 32'(0));
    endtask

    task automatic check_empty(input string nm);
        check(exp_addr_q.size() == 0, {nm, "_fetch_q"}, 32'(exp_addr_q.size()), 32'(0));
        check(exp_wr_q.size()   == 0, {nm, "_write_q"}, 32'(exp_wr_q.size()),   32'(0));
        check(exp_done_q.size() == 0, {nm, "_done_q"},  32'(exp_done_q.size()), 32'(0));
    endtask

    logic [24:0] ctl_now;
    assign ctl_now = {dif.writeEnable, dif.muxSel, dif.inputData, dif.dstSel, dif.A_sel, dif.B_sel, dif.OP_Sel};

    initial begin
        int w0;
        dif.start      = 1'b0;
        dif.start_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check(dif.busy == 1'b0,      "rst_busy", 32'(dif.busy), 32'(0));
        check(dif.done == 1'b0,      "rst_done", 32'(dif.done), 32'(0));
        check(dif.imem_req == 1'b0,  "rst_req",  32'(dif.imem_req), 32'(0));
        check(dif.imem_addr == 8'h0, "rst_addr", 32'(dif.imem_addr), 32'(0));
        check(ctl_now == '0,         "rst_ctl",  32'(ctl_now), 32'(0));
        @(negedge clk); #3;
        rst_n = 1'b1;

        // Program: LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT at 0x10, immediate ack
        mem[8'h10] = 16'hF105; mem[8'h11] = 16'hF203;
        mem[8'h12] = 16'h0312; mem[8'h13] = 16'hE000;
        ack_dly = 0;
        exp_addr_q.push_back(8'h10); exp_addr_q.push_back(8'h11);
        exp_addr_q.push_back(8'h12); exp_addr_q.push_back(8'h13);
        exp_wr_q.push_back(mk(4'd1, 1'b1, 8'h05, 4'd0, 4'd0, 4'd0));
        exp_wr_q.push_back(mk(4'd2, 1'b1, 8'h03, 4'd0, 4'd0, 4'd0));
        exp_wr_q.push_back(mk(4'd3, 1'b0, 8'h03, 4'd1, 4'd2, 4'd0));
        exp_done_q.push_back(1);
        w0 = wr_cnt;
        pulse_start(8'h10);
        check(dif.busy == 1'b1, "busy_after_start", 32'(dif.busy), 32'(1));
        wait_done(200);
        check(wr_cnt - w0 == 3, "t1_write_count", 32'(wr_cnt - w0), 32'(3));
        check_empty("t1");

        // Same program, ack delayed 3 cycles per fetch; A/B/OP now held from the ADD
        ack_dly = 3;
        exp_addr_q.push_back(8'h10); exp_addr_q.push_back(8'h11);
        exp_addr_q.push_back(8'h12); exp_addr_q.push_back(8'h13);
        exp_wr_q.push_back(mk(4'd1, 1'b1, 8'h05, 4'd1, 4'd2, 4'd0));
        exp_wr_q.push_back(mk(4'd2, 1'b1, 8'h03, 4'd1, 4'd2, 4'd0));
        exp_wr_q.push_back(mk(4'd3, 1'b0, 8'h03, 4'd1, 4'd2, 4'd0));
        exp_done_q.push_back(1);
        w0 = wr_cnt;
        pulse_start(8'h10);
        wait_done(300);
        check(wr_cnt - w0 == 3, "t2_write_count", 32'(wr_cnt - w0), 32'(3));
        check_empty("t2");

        // PC wrap: LDI r5,0xA7 at 0xFF, HALT at 0x00
        ack_dly = 0;
        mem[8'hFF] = 16'hF5A7; mem[8'h00] = 16'hE000;
        exp_addr_q.push_back(8'hFF); exp_addr_q.push_back(8'h00);
        exp_wr_q.push_back(mk(4'd5, 1'b1, 8'hA7, 4'd1, 4'd2, 4'd0));
        exp_done_q.push_back(1);
        w0 = wr_cnt;
        pulse_start(8'hFF);
        wait_done(200);
        check(wr_cnt - w0 == 1, "t3_write_count", 32'(wr_cnt - w0), 32'(1));
        check_empty("t3");

        // Reset while the first write strobe is high
        ack_dly = 1;
        mem[8'h20] = 16'hF411; mem[8'h21] = 16'h1644; mem[8'h22] = 16'hE000;
        exp_addr_q.push_back(8'h20);
        exp_wr_q.push_back(mk(4'd4, 1'b1, 8'h11, 4'd1, 4'd2, 4'd0));
        pulse_start(8'h20);
        for (int i = 0; i < 50 && !dif.writeEnable; i++) begin
            @(negedge clk); #2;
        end
        check(dif.writeEnable == 1'b1, "we_seen_before_reset", 32'(dif.writeEnable), 32'(1));
        rst_n = 1'b0;
        #1;
        check(ctl_now == '0,         "mid_rst_ctl",  32'(ctl_now), 32'(0));
        check(dif.busy == 1'b0,      "mid_rst_busy", 32'(dif.busy), 32'(0));
        check(dif.imem_req == 1'b0,  "mid_rst_req",  32'(dif.imem_req), 32'(0));
        check(dif.imem_addr == 8'h0, "mid_rst_addr", 32'(dif.imem_addr), 32'(0));
        repeat (2) @(posedge clk);
        check(dif.imem_req == 1'b0,  "rst_hold_req", 32'(dif.imem_req), 32'(0));
        @(negedge clk); #3;
        rst_n = 1'b1;
        check_empty("t4a");
        exp_addr_q.push_back(8'h20); exp_addr_q.push_back(8'h21); exp_addr_q.push_back(8'h22);
        exp_wr_q.push_back(mk(4'd4, 1'b1, 8'h11, 4'd0, 4'd0, 4'd0));
        exp_wr_q.push_back(mk(4'd6, 1'b0, 8'h11, 4'd4, 4'd4, 4'd1));
        exp_done_q.push_back(1);
        w0 = wr_cnt;
        pulse_start(8'h20);
        wait_done(200);
        check(wr_cnt - w0 == 2, "t4_write_count", 32'(wr_cnt - w0), 32'(2));
        check_empty("t4b");

        // start while busy ignored; stray acks outside FETCH ignored
        ack_dly = 2;
        stray   = 1'b1;
        mem[8'h40] = 16'hF742; mem[8'h41] = 16'h2877; mem[8'h42] = 16'hE000;
        mem[8'h80] = 16'hF0AA;
        exp_addr_q.push_back(8'h40); exp_addr_q.push_back(8'h41); exp_addr_q.push_back(8'h42);
        exp_wr_q.push_back(mk(4'd7, 1'b1, 8'h42, 4'd4, 4'd4, 4'd1));
        exp_wr_q.push_back(mk(4'd8, 1'b0, 8'h42, 4'd7, 4'd7, 4'd2));
        exp_done_q.push_back(1);
        w0 = wr_cnt;
        pulse_start(8'h40);
        repeat (2) @(posedge clk);
        pulse_start(8'h80);
        wait_done(300);
        stray = 1'b0;
        check(wr_cnt - w0 == 2, "t5_write_count", 32'(wr_cnt - w0), 32'(2));
        check_empty("t5");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
